// File: rtl/mac_seq_ctrl.sv
// Upstream sequencer for mac_wrapper: streams activation vectors against four held weights,
// feeds the MAC output back as c, and returns the accumulated dot product on a result port.
module mac_seq_ctrl #(
  parameter int unsigned bw      = 4,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned len_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               w_load,
  input  logic [4*bw-1:0]    w_in,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  input  logic               act_valid,
  output logic               act_ready,
  input  logic [4*bw-1:0]    act_in,
  output logic [bw-1:0]      a0,
  output logic [bw-1:0]      a1,
  output logic [bw-1:0]      a2,
  output logic [bw-1:0]      a3,
  output logic [bw-1:0]      b0,
  output logic [bw-1:0]      b1,
  output logic [bw-1:0]      b2,
  output logic [bw-1:0]      b3,
  output logic [psum_bw-1:0] c,
  input  logic [psum_bw-1:0] mac_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [psum_bw-1:0] res
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [len_bw-1:0] LenOne = 1;

  state_e              state_q, state_d;
  logic [4*bw-1:0]     w_q, w_d;
  logic [len_bw-1:0]   len_q, len_d;
  logic [len_bw-1:0]   count_q, count_d;
  logic                started_q, started_d;
  logic [psum_bw-1:0]  res_q, res_d;
  logic                accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      w_q       <= '0;
      len_q     <= '0;
      count_q   <= '0;
      started_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      len_q     <= len_d;
      count_q   <= count_d;
      started_q <= started_d;
      res_q     <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    len_d     = len_q;
    count_d   = count_q;
    started_d = started_q;
    res_d     = res_q;
    act_ready = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (w_load) w_d = w_in;
        if (start) begin
          len_d     = len;
          count_d   = '0;
          started_d = 1'b0;
          // An empty vector list completes immediately with a zero result.
          if (len == '0) begin
            res_d   = '0;
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        act_ready = (count_q < len_q);
        accept    = act_valid & act_ready;
        if (accept) begin
          count_d   = count_q + LenOne;
          started_d = 1'b1;
          if (count_q == len_q - LenOne) state_d = StDrain;
        end
      end
      StDrain: begin
        // The last vector's product has now been folded into mac_out.
        res_d   = mac_out;
        state_d = StDone;
      end
      StDone: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d   = StIdle;
          started_d = 1'b0;
          count_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Cycles without an accepted vector drive zeros so the running sum passes through unchanged.
  assign a0 = accept ? act_in[0*bw +: bw] : '0;
  assign a1 = accept ? act_in[1*bw +: bw] : '0;
  assign a2 = accept ? act_in[2*bw +: bw] : '0;
  assign a3 = accept ? act_in[3*bw +: bw] : '0;

  assign b0 = w_q[0*bw +: bw];
  assign b1 = w_q[1*bw +: bw];
  assign b2 = w_q[2*bw +: bw];
  assign b3 = w_q[3*bw +: bw];

  assign c   = started_q ? mac_out : '0;
  assign res = res_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with a behavioural mac_wrapper model and a result
// scoreboard.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_load;
  logic [15:0] w_in;
  logic        start;
  logic [7:0]  len;
  logic        act_valid;
  logic        act_ready;
  logic [15:0] act_in;
  logic [3:0]  a0, a1, a2, a3, b0, b1, b2, b3;
  logic [15:0] c;
  logic [15:0] mac_out = '0;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [15:0] exp_q[$];

  mac_seq_ctrl #(.bw(4), .psum_bw(16), .len_bw(8)) dut (
    .clk(clk), .reset(reset), .w_load(w_load), .w_in(w_in), .start(start), .len(len),
    .act_valid(act_valid), .act_ready(act_ready), .act_in(act_in),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .c(c), .mac_out(mac_out), .res_valid(res_valid), .res_ready(res_ready), .res(res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unsigned activations times two's-complement weights, summed mod 2^16.
  function automatic logic [15:0] lane_dot(input logic [15:0] w, input logic [15:0] act);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'(act[i*4 +: 4]) * int'($signed(w[i*4 +: 4]));
    return s[15:0];
  endfunction

  // mac_wrapper: registers a, b, c and produces their dot product plus c one cycle later.
  always @(posedge clk) mac_out <= c + lane_dot({b3, b2, b1, b0}, {a3, a2, a1, a0});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l, input logic ld, input logic [15:0] w);
    start = 1'b1; len = l; w_load = ld; w_in = w;
    tick();
    start = 1'b0; w_load = 1'b0;
  endtask

  task automatic send_vec(input logic [15:0] v, output bit ok, output int acc);
    act_valid = 1'b1; act_in = v; ok = 1'b0; acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (act_ready) begin ok = 1'b1; acc = cyc; end
      tick();
      if (ok) break;
    end
    act_valid = 1'b0;
  endtask

  task automatic wait_res(output bit ok, output int vc);
    ok = 1'b0; vc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1'b1; vc = cyc; break; end
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; w_load = 1'b1; w_in = 16'hFFFF; start = 1'b1; len = 8'd5;
    act_valid = 1'b1; act_in = 16'hFFFF; res_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_checks++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL reset_act_ready got %b want 0", act_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    n_checks++; if (res !== 16'h0) begin n_fail++; $display("FAIL reset_res got %h want 0000", res); end
    n_checks++; if ({b3, b2, b1, b0} !== 16'h0) begin
      n_fail++; $display("FAIL reset_weights got %h want 0000", {b3, b2, b1, b0});
    end
    n_checks++; if (c !== 16'h0) begin n_fail++; $display("FAIL reset_c got %h want 0000", c); end
    reset = 1'b0; w_load = 1'b0; w_in = '0; start = 1'b0; len = '0; act_valid = 1'b0; act_in = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, okr; int acc1, acc2, vc; logic [15:0] e;
    w_load = 1'b1; w_in = 16'h4321;
    tick();
    w_load = 1'b0;
    @(negedge clk);
    n_checks++; if ({b3, b2, b1, b0} !== 16'h4321) begin
      n_fail++; $display("FAIL b2b_weights got %h want 4321", {b3, b2, b1, b0});
    end
    tick();
    e = lane_dot(16'h4321, 16'h1111) + lane_dot(16'h4321, 16'h0002);
    exp_q.push_back(e);
    do_start(8'd2, 1'b0, 16'h0);
    send_vec(16'h1111, ok1, acc1);
    send_vec(16'h0002, ok2, acc2);
    n_checks++; if (!(ok1 && ok2) || acc2 - acc1 != 1) begin
      n_fail++; $display("FAIL b2b_accept_gap got %0d want 1", acc2 - acc1);
    end
    wait_res(okr, vc);
    n_checks++; if (!okr || vc - acc2 != 2) begin
      n_fail++; $display("FAIL b2b_latency got %0d want 2", vc - acc2);
    end
    n_checks++; if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_scoreboard empty"); end
    else begin e = exp_q.pop_front(); if (res !== e) begin n_fail++; $display("FAIL b2b_res got %h want %h", res, e); end end
    consume();
    @(negedge clk);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_res_valid_drop got %b want 0", res_valid); end
    tick();
  endtask

  task automatic test_gaps();
    bit ok1, ok2, okr; int acc1, acc2, vc; logic [15:0] e;
    e = lane_dot(16'h4321, 16'h1111) + lane_dot(16'h4321, 16'h0002);
    exp_q.push_back(e);
    do_start(8'd2, 1'b0, 16'h0);
    send_vec(16'h1111, ok1, acc1);
    for (int g = 0; g < 3; g++) begin
      act_valid = 1'b0; act_in = 16'hFFFF;
      @(negedge clk);
      n_checks++; if ({a3, a2, a1, a0} !== 16'h0 || act_ready !== 1'b1) begin
        n_fail++; $display("FAIL gap_lanes got a=%h rdy=%b want a=0000 rdy=1", {a3, a2, a1, a0}, act_ready);
      end
      tick();
    end
    send_vec(16'h0002, ok2, acc2);
    wait_res(okr, vc);
    n_checks++; if (!(ok1 && ok2 && okr) || vc - acc2 != 2) begin
      n_fail++; $display("FAIL gap_latency got %0d want 2", vc - acc2);
    end
    n_checks++; if (exp_q.size() == 0) begin n_fail++; $display("FAIL gap_scoreboard empty"); end
    else begin e = exp_q.pop_front(); if (res !== e) begin n_fail++; $display("FAIL gap_res got %h want %h", res, e); end end
    consume();
    tick();
  endtask

  task automatic test_negative();
    bit ok1, okr; int acc1, vc; logic [15:0] e;
    // Weights loaded in the same cycle as start must apply to the run.
    exp_q.push_back(lane_dot(16'h8888, 16'hFFFF));
    do_start(8'd1, 1'b1, 16'h8888);
    send_vec(16'hFFFF, ok1, acc1);
    wait_res(okr, vc);
    n_checks++; if (!(ok1 && okr) || vc - acc1 != 2) begin
      n_fail++; $display("FAIL neg_latency got %0d want 2", vc - acc1);
    end
    n_checks++; if (exp_q.size() == 0) begin n_fail++; $display("FAIL neg_scoreboard empty"); end
    else begin e = exp_q.pop_front(); if (res !== e) begin n_fail++; $display("FAIL neg_res got %h want %h", res, e); end end
    consume();
    tick();
  endtask

  task automatic test_wrap();
    bit ok, all_ok, okr; int acc, vc; logic [15:0] e;
    e = '0;
    for (int i = 0; i < 255; i++) e = e + lane_dot(16'h7777, 16'hFFFF);
    exp_q.push_back(e);
    do_start(8'd255, 1'b1, 16'h7777);
    all_ok = 1'b1;
    for (int i = 0; i < 255; i++) begin send_vec(16'hFFFF, ok, acc); all_ok &= ok; end
    n_checks++; if (!all_ok) begin n_fail++; $display("FAIL wrap_accepts got timeout want 255 accepts"); end
    act_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_ready_after_len got %b want 0", act_ready); end
    act_valid = 1'b0;
    wait_res(okr, vc);
    n_checks++; if (!okr || vc - acc != 2) begin n_fail++; $display("FAIL wrap_latency got %0d want 2", vc - acc); end
    n_checks++; if (exp_q.size() == 0) begin n_fail++; $display("FAIL wrap_scoreboard empty"); end
    else begin e = exp_q.pop_front(); if (res !== e) begin n_fail++; $display("FAIL wrap_res got %h want %h", res, e); end end
    for (int k = 0; k < 5; k++) begin
      tick();
      start = (k == 1); len = 8'd3;
      @(negedge clk);
      n_checks++; if (res_valid !== 1'b1 || res !== e) begin
        n_fail++; $display("FAIL wrap_hold got v=%b r=%h want v=1 r=%h", res_valid, res, e);
      end
    end
    tick();
    start = 1'b0; len = '0;
    consume();
    act_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (res_valid !== 1'b0 || act_ready !== 1'b0) begin
      n_fail++; $display("FAIL wrap_idle got v=%b rdy=%b want v=0 rdy=0", res_valid, act_ready);
    end
    act_valid = 1'b0;
    tick();
  endtask

  task automatic test_len_zero_and_reset();
    bit ok; int acc; logic [15:0] e;
    exp_q.push_back(16'h0);
    do_start(8'd0, 1'b0, 16'h0);
    @(negedge clk);
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL len0_res_valid got %b want 1", res_valid); end
    n_checks++; if (exp_q.size() == 0) begin n_fail++; $display("FAIL len0_scoreboard empty"); end
    else begin e = exp_q.pop_front(); if (res !== e) begin n_fail++; $display("FAIL len0_res got %h want %h", res, e); end end
    consume();
    tick();
    do_start(8'd4, 1'b1, 16'h1111);
    send_vec(16'h1111, ok, acc);
    send_vec(16'h2222, ok, acc);
    reset = 1'b1; act_valid = 1'b1; act_in = 16'h3333;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if ({b3, b2, b1, b0} !== 16'h0) begin
      n_fail++; $display("FAIL midrun_reset_weights got %h want 0000", {b3, b2, b1, b0});
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      n_checks++; if (res_valid !== 1'b0 || act_ready !== 1'b0) begin
        n_fail++; $display("FAIL midrun_reset_idle got v=%b rdy=%b want 0 0", res_valid, act_ready);
      end
    end
    act_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_negative();
    test_wrap();
    test_len_zero_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
